// File: rtl/snake_lcd_pkg.sv
// snake_lcd_pkg
//   Shared types and constants for the snake display path: object codes,
//   RGB565 tile colours, the LCD command bytes used by the tile writer and
//   the tile writer's state encoding. Also holds two small byte-select helpers.
package snake_lcd_pkg;

    typedef enum logic [2:0] {
        OBJ_EMPTY  = 3'd0,
        OBJ_BODY   = 3'd1,
        OBJ_HEAD   = 3'd2,
        OBJ_APPLE  = 3'd3,
        OBJ_BORDER = 3'd4
    } obj_code_t;

    localparam logic [15:0] COL_EMPTY  = 16'h0000;
    localparam logic [15:0] COL_BODY   = 16'h07E0;
    localparam logic [15:0] COL_HEAD   = 16'h03E0;
    localparam logic [15:0] COL_APPLE  = 16'hF800;
    localparam logic [15:0] COL_BORDER = 16'hFFFF;

    localparam logic [7:0] CMD_SLPOUT = 8'h11;
    localparam logic [7:0] CMD_COLMOD = 8'h3A;
    localparam logic [7:0] COLMOD_565 = 8'h55;
    localparam logic [7:0] CMD_DISPON = 8'h29;
    localparam logic [7:0] CMD_CASET  = 8'h2A;
    localparam logic [7:0] CMD_PASET  = 8'h2B;
    localparam logic [7:0] CMD_RAMWR  = 8'h2C;

    typedef enum logic [2:0] {
        S_INIT_SLP,
        S_INIT_WAIT,
        S_INIT_CFG,
        S_DONE,
        S_IDLE,
        S_WIN_COL,
        S_WIN_PAGE,
        S_PIX
    } state_t;

    // Codes 5-7 are not drawable objects and paint as background.
    function automatic logic [15:0] colour_of(input obj_code_t code);
        case (code)
            OBJ_BODY:   return COL_BODY;
            OBJ_HEAD:   return COL_HEAD;
            OBJ_APPLE:  return COL_APPLE;
            OBJ_BORDER: return COL_BORDER;
            default:    return COL_EMPTY;
        endcase
    endfunction

    // Window parameter bytes 1..4 after CASET/PASET: start MSB, start LSB, end MSB, end LSB.
    function automatic logic [7:0] win_byte(input logic [2:0] idx,
                                            input logic [15:0] lo,
                                            input logic [15:0] hi);
        case (idx)
            3'd1:    return lo[15:8];
            3'd2:    return lo[7:0];
            3'd3:    return hi[15:8];
            default: return hi[7:0];
        endcase
    endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// lcd_byte_writer
//   Two-clock 8080 write strobe engine. A byte accepted on start&&ready is
//   driven for one clock with lcd_wrx low (phase A) then held one clock with
//   lcd_wrx high (phase B). ready is high in phase B so the next byte can be
//   accepted without a gap.
// Ports
//   clk, rst            clock, async active-high reset
//   start, byte_in, dc  request to write byte_in with data/command select dc
//   ready               a start this cycle will be accepted
//   lcd_d/dcx/wrx       registered bus outputs
module lcd_byte_writer (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] byte_in,
    input  logic       dc,
    output logic       ready,
    output logic [7:0] lcd_d,
    output logic       lcd_dcx,
    output logic       lcd_wrx
);

    logic [7:0] d_q, d_d;
    logic       dcx_q, dcx_d;
    logic       wrx_q, wrx_d;
    logic       phase_a_q, phase_a_d;

    assign ready = !phase_a_q;

    always_comb begin
        d_d       = d_q;
        dcx_d     = dcx_q;
        wrx_d     = 1'b1;
        phase_a_d = 1'b0;
        if (start && ready) begin
            d_d       = byte_in;
            dcx_d     = dc;
            wrx_d     = 1'b0;
            phase_a_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q       <= 8'h00;
            dcx_q     <= 1'b1;
            wrx_q     <= 1'b1;
            phase_a_q <= 1'b0;
        end else begin
            d_q       <= d_d;
            dcx_q     <= dcx_d;
            wrx_q     <= wrx_d;
            phase_a_q <= phase_a_d;
        end
    end

    assign lcd_d   = d_q;
    assign lcd_dcx = dcx_q;
    assign lcd_wrx = wrx_q;

endmodule

// File: rtl/tile_cmd_writer.sv
// tile_cmd_writer
//   Runs the panel power-up sequence after reset, then paints one grid cell
//   per accepted diff request as a TILE_W x TILE_H RGB565 block.
// Ports
//   clk, rst        clock, async active-high reset
//   diff, x, y      cell-update request and cell coordinates
//   obj_code        object in the cell
//   cmd_done        one-cycle pulse when init or a tile is finished/rejected
//   busy            low only while waiting for a request
//   lcd_*           8080 bus (lcd_csx owned here, the rest by lcd_byte_writer)
//
// state       | meaning
// S_INIT_SLP  | send SLPOUT
// S_INIT_WAIT | panel wake-up delay, bus deselected
// S_INIT_CFG  | send COLMOD 565 and DISPON
// S_DONE      | cmd_done cycle
// S_IDLE      | wait for diff
// S_WIN_COL   | CASET parameters
// S_WIN_PAGE  | PASET command and parameters
// S_PIX       | RAMWR command and pixel bytes
module tile_cmd_writer
    import snake_lcd_pkg::*;
#(
    parameter int GRID_W    = 16,
    parameter int GRID_H    = 12,
    parameter int TILE_W    = 20,
    parameter int TILE_H    = 20,
    parameter int INIT_WAIT = 1_200_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       diff,
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic [2:0] obj_code,
    output logic       cmd_done,
    output logic       busy,
    output logic [7:0] lcd_d,
    output logic       lcd_dcx,
    output logic       lcd_wrx,
    output logic       lcd_csx
);

    localparam int TILE_N = TILE_W * TILE_H;
    localparam int PIX_W  = $clog2(TILE_N + 1);
    localparam int WAIT_W = $clog2(INIT_WAIT + 1);
    localparam logic [4:0] GRID_W_L = 5'(GRID_W);
    localparam logic [4:0] GRID_H_L = 5'(GRID_H);

    state_t             state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [PIX_W-1:0]   pix_cnt_q, pix_cnt_d;
    logic               last_q, last_d;
    logic               csx_q, csx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [3:0]         x_q, x_d, y_q, y_d;
    logic [2:0]         code_q, code_d;

    logic               wr_start, wr_dc, wr_ready;
    logic [7:0]         wr_byte;
    logic [15:0]        x0, x1, y0, y1, colour;
    logic               in_range;

    assign in_range = ({1'b0, x} < GRID_W_L) && ({1'b0, y} < GRID_H_L);
    assign x0       = 16'(x_q) * 16'(TILE_W);
    assign x1       = x0 + 16'(TILE_W - 1);
    assign y0       = 16'(y_q) * 16'(TILE_H);
    assign y1       = y0 + 16'(TILE_H - 1);
    assign colour   = colour_of(obj_code_t'(code_q));

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        wait_cnt_d = wait_cnt_q;
        pix_cnt_d  = pix_cnt_q;
        last_d     = last_q;
        csx_d      = csx_q;
        x_d        = x_q;
        y_d        = y_q;
        code_d     = code_q;
        wr_start   = 1'b0;
        wr_byte    = 8'h00;
        wr_dc      = 1'b0;

        case (state_q)
            S_INIT_SLP: begin
                if (wr_ready) begin
                    if (idx_q == 3'd0) begin
                        wr_start = 1'b1;
                        wr_byte  = CMD_SLPOUT;
                        csx_d    = 1'b0;
                        idx_d    = 3'd1;
                    end else begin
                        state_d    = S_INIT_WAIT;
                        csx_d      = 1'b1;
                        wait_cnt_d = WAIT_W'(INIT_WAIT - 1);
                    end
                end
            end
            S_INIT_WAIT: begin
                // The COLMOD byte is launched on the last wait clock so the
                // deselected gap is exactly INIT_WAIT clocks.
                if (wait_cnt_q == '0) begin
                    wr_start = 1'b1;
                    wr_byte  = CMD_COLMOD;
                    csx_d    = 1'b0;
                    idx_d    = 3'd1;
                    state_d  = S_INIT_CFG;
                end else begin
                    wait_cnt_d = wait_cnt_q - WAIT_W'(1);
                end
            end
            S_INIT_CFG: begin
                if (wr_ready) begin
                    case (idx_q)
                        3'd1: begin
                            wr_start = 1'b1;
                            wr_byte  = COLMOD_565;
                            wr_dc    = 1'b1;
                            idx_d    = 3'd2;
                        end
                        3'd2: begin
                            wr_start = 1'b1;
                            wr_byte  = CMD_DISPON;
                            idx_d    = 3'd3;
                        end
                        default: begin
                            state_d = S_DONE;
                            csx_d   = 1'b1;
                        end
                    endcase
                end
            end
            S_DONE: state_d = S_IDLE;
            S_IDLE: begin
                if (diff) begin
                    x_d    = x;
                    y_d    = y;
                    code_d = obj_code;
                    if (in_range) begin
                        wr_start = 1'b1;
                        wr_byte  = CMD_CASET;
                        csx_d    = 1'b0;
                        idx_d    = 3'd1;
                        state_d  = S_WIN_COL;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_WIN_COL: begin
                if (wr_ready) begin
                    wr_start = 1'b1;
                    wr_byte  = win_byte(idx_q, x0, x1);
                    wr_dc    = 1'b1;
                    if (idx_q == 3'd4) begin
                        state_d = S_WIN_PAGE;
                        idx_d   = 3'd0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            S_WIN_PAGE: begin
                if (wr_ready) begin
                    wr_start = 1'b1;
                    if (idx_q == 3'd0) begin
                        wr_byte = CMD_PASET;
                    end else begin
                        wr_byte = win_byte(idx_q, y0, y1);
                        wr_dc   = 1'b1;
                    end
                    if (idx_q == 3'd4) begin
                        state_d   = S_PIX;
                        idx_d     = 3'd0;
                        pix_cnt_d = PIX_W'(TILE_N - 1);
                        last_d    = 1'b0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            S_PIX: begin
                // idx: 0 = RAMWR pending, 1 = colour MSB next, 2 = colour LSB next.
                if (wr_ready) begin
                    if (last_q) begin
                        state_d = S_DONE;
                        csx_d   = 1'b1;
                    end else begin
                        wr_start = 1'b1;
                        case (idx_q)
                            3'd0: begin
                                wr_byte = CMD_RAMWR;
                                idx_d   = 3'd1;
                            end
                            3'd1: begin
                                wr_byte = colour[15:8];
                                wr_dc   = 1'b1;
                                idx_d   = 3'd2;
                            end
                            default: begin
                                wr_byte = colour[7:0];
                                wr_dc   = 1'b1;
                                idx_d   = 3'd1;
                                if (pix_cnt_q == '0) last_d = 1'b1;
                                else pix_cnt_d = pix_cnt_q - PIX_W'(1);
                            end
                        endcase
                    end
                end
            end
            default: state_d = S_INIT_SLP;
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_INIT_SLP;
            idx_q      <= 3'd0;
            wait_cnt_q <= '0;
            pix_cnt_q  <= '0;
            last_q     <= 1'b0;
            csx_q      <= 1'b1;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            x_q        <= 4'd0;
            y_q        <= 4'd0;
            code_q     <= 3'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            wait_cnt_q <= wait_cnt_d;
            pix_cnt_q  <= pix_cnt_d;
            last_q     <= last_d;
            csx_q      <= csx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            x_q        <= x_d;
            y_q        <= y_d;
            code_q     <= code_d;
        end
    end

    lcd_byte_writer u_wr (
        .clk     (clk),
        .rst     (rst),
        .start   (wr_start),
        .byte_in (wr_byte),
        .dc      (wr_dc),
        .ready   (wr_ready),
        .lcd_d   (lcd_d),
        .lcd_dcx (lcd_dcx),
        .lcd_wrx (lcd_wrx)
    );

    assign lcd_csx  = csx_q;
    assign busy     = busy_q;
    assign cmd_done = done_q;

endmodule

// File: tb/tb_tile_cmd_writer.sv
module tb_tile_cmd_writer;

    localparam int TW = 2;
    localparam int TH = 2;
    localparam int IW = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       diff = 1'b0;
    logic [3:0] x = 4'd0, y = 4'd0;
    logic [2:0] code = 3'd0;
    logic       cmd_done, busy, lcd_dcx, lcd_wrx, lcd_csx;
    logic [7:0] lcd_d;

    tile_cmd_writer #(.GRID_W(16), .GRID_H(12), .TILE_W(TW), .TILE_H(TH), .INIT_WAIT(IW)) dut (
        .clk(clk), .rst(rst), .diff(diff), .x(x), .y(y), .obj_code(code),
        .cmd_done(cmd_done), .busy(busy), .lcd_d(lcd_d), .lcd_dcx(lcd_dcx),
        .lcd_wrx(lcd_wrx), .lcd_csx(lcd_csx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       dcx, wrx, csx, done, busy, care_d;
    } exp_t;

    exp_t       exp_q[$];
    logic [8:0] cap_q[$];
    int         total = 0, bad = 0, cyc = 0, done_cyc = -1, done_cnt = 0, req_cyc = 0;
    logic       model_idle = 1'b0;

    logic [7:0] lit2 [19] = '{8'h2A, 8'h00, 8'h06, 8'h00, 8'h07, 8'h2B, 8'h00, 8'h0A, 8'h00, 8'h0B,
                              8'h2C, 8'hF8, 8'h00, 8'hF8, 8'h00, 8'hF8, 8'h00, 8'hF8, 8'h00};

    function automatic logic [15:0] col_of(input int c);
        case (c)
            1: return 16'h07E0;
            2: return 16'h03E0;
            3: return 16'hF800;
            4: return 16'hFFFF;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic push_byte(input logic dc, input logic [7:0] b);
        exp_q.push_back('{d: b, dcx: dc, wrx: 1'b0, csx: 1'b0, done: 1'b0, busy: 1'b1, care_d: 1'b1});
        exp_q.push_back('{d: b, dcx: dc, wrx: 1'b1, csx: 1'b0, done: 1'b0, busy: 1'b1, care_d: 1'b1});
    endtask

    task automatic push_done();
        exp_q.push_back('{d: 8'h00, dcx: 1'b1, wrx: 1'b1, csx: 1'b1, done: 1'b1, busy: 1'b1, care_d: 1'b0});
    endtask

    task automatic push_tile(input int cx, input int cy, input int cc);
        int x0, x1, y0, y1;
        logic [15:0] col;
        x0 = cx * TW; x1 = x0 + TW - 1;
        y0 = cy * TH; y1 = y0 + TH - 1;
        col = col_of(cc);
        push_byte(1'b0, 8'h2A);
        push_byte(1'b1, 8'((x0 >> 8) & 255)); push_byte(1'b1, 8'(x0 & 255));
        push_byte(1'b1, 8'((x1 >> 8) & 255)); push_byte(1'b1, 8'(x1 & 255));
        push_byte(1'b0, 8'h2B);
        push_byte(1'b1, 8'((y0 >> 8) & 255)); push_byte(1'b1, 8'(y0 & 255));
        push_byte(1'b1, 8'((y1 >> 8) & 255)); push_byte(1'b1, 8'(y1 & 255));
        push_byte(1'b0, 8'h2C);
        for (int p = 0; p < TW * TH; p++) begin
            push_byte(1'b1, col[15:8]);
            push_byte(1'b1, col[7:0]);
        end
        push_done();
    endtask

    task automatic push_init();
        push_byte(1'b0, 8'h11);
        for (int i = 0; i < IW; i++)
            exp_q.push_back('{d: 8'h00, dcx: 1'b1, wrx: 1'b1, csx: 1'b1, done: 1'b0, busy: 1'b1, care_d: 1'b0});
        push_byte(1'b0, 8'h3A);
        push_byte(1'b1, 8'h55);
        push_byte(1'b0, 8'h29);
        push_done();
    endtask

    task automatic check_now();
        exp_t e;
        logic ok;
        if (exp_q.size() == 0)
            e = '{d: 8'h00, dcx: 1'b1, wrx: 1'b1, csx: 1'b1, done: 1'b0, busy: 1'b0, care_d: 1'b0};
        else
            e = exp_q.pop_front();
        model_idle = !e.busy;
        if (lcd_wrx == 1'b0) cap_q.push_back({lcd_dcx, lcd_d});
        if (cmd_done) begin done_cyc = cyc; done_cnt++; end
        ok = (lcd_wrx === e.wrx) && (lcd_csx === e.csx) && (cmd_done === e.done) && (busy === e.busy) &&
             (!e.care_d || (lcd_d === e.d && lcd_dcx === e.dcx));
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL cycle %0d: got d=%h dcx=%b wrx=%b csx=%b done=%b busy=%b want d=%h dcx=%b wrx=%b csx=%b done=%b busy=%b",
                     cyc, lcd_d, lcd_dcx, lcd_wrx, lcd_csx, cmd_done, busy,
                     e.d, e.dcx, e.wrx, e.csx, e.done, e.busy);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        check_now();
    endtask

    task automatic drive(input logic d, input int cx, input int cy, input int cc);
        diff = d; x = 4'(cx); y = 4'(cy); code = 3'(cc);
        if (d && model_idle) begin
            if (cx < 16 && cy < 12) push_tile(cx, cy, cc);
            else push_done();
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        diff = 1'b0;
        while (!(model_idle && exp_q.size() == 0) && n < budget) begin
            step();
            n++;
        end
        total++;
        if (!(model_idle && exp_q.size() == 0)) begin
            bad++;
            $display("FAIL idle_timeout: still busy after %0d cycles, want idle", budget);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        total++;
        if (!(cmd_done === 1'b0 && busy === 1'b1 && lcd_d === 8'h00 && lcd_dcx === 1'b1 &&
              lcd_wrx === 1'b1 && lcd_csx === 1'b1)) begin
            bad++;
            $display("FAIL %s: got done=%b busy=%b d=%h dcx=%b wrx=%b csx=%b want 0 1 00 1 1 1",
                     tag, cmd_done, busy, lcd_d, lcd_dcx, lcd_wrx, lcd_csx);
        end
    endtask

    task automatic do_init();
        logic found;
        found = 1'b0;
        exp_q.delete();
        model_idle = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge clk);
            cyc++;
            if (lcd_wrx === 1'b0) begin
                found = 1'b1;
            end else begin
                total++;
                if (!(busy === 1'b1 && lcd_csx === 1'b1 && cmd_done === 1'b0)) begin
                    bad++;
                    $display("FAIL init_pre: got busy=%b csx=%b done=%b want 1 1 0", busy, lcd_csx, cmd_done);
                end
            end
        end
        if (found) begin
            push_init();
            check_now();
            wait_idle(60);
        end else begin
            total++; bad++;
            $display("FAIL init_start: no write strobe within 8 cycles of reset release, want one");
        end
    endtask

    task automatic expect_val(input string tag, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic directed_req(input int cx, input int cy, input int cc);
        cap_q.delete();
        done_cyc = -1;
        done_cnt = 0;
        req_cyc = cyc;
        drive(1'b1, cx, cy, cc);
        step();
        diff = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_vals("reset_values");
        rst = 1'b0;
        do_init();

        // cell (3,5) APPLE, with a stray request pulsed in the middle of the burst
        directed_req(3, 5, 3);
        repeat (10) step();
        drive(1'b1, 1, 1, 1);
        step();
        diff = 1'b0;
        wait_idle(100);
        expect_val("t2_nbytes", cap_q.size(), 19);
        for (int i = 0; i < 19 && i < cap_q.size(); i++)
            expect_val($sformatf("t2_byte%0d", i), int'(cap_q[i]),
                       int'({(i == 0 || i == 5 || i == 10) ? 1'b0 : 1'b1, lit2[i]}));
        expect_val("t2_done_latency", done_cyc - req_cyc, 39);
        expect_val("t5_done_count", done_cnt, 1);

        // corner cell, BORDER then code 6
        directed_req(15, 11, 4);
        wait_idle(100);
        if (cap_q.size() == 19) begin
            expect_val("t3_x0l", int'(cap_q[2]), 9'h11E);
            expect_val("t3_x1l", int'(cap_q[4]), 9'h11F);
            expect_val("t3_y0l", int'(cap_q[7]), 9'h116);
            expect_val("t3_y1l", int'(cap_q[9]), 9'h117);
            expect_val("t3_pix_hi", int'(cap_q[11]), 9'h1FF);
            expect_val("t3_pix_lo", int'(cap_q[18]), 9'h1FF);
        end else expect_val("t3_nbytes", cap_q.size(), 19);
        directed_req(15, 11, 6);
        wait_idle(100);
        if (cap_q.size() == 19) begin
            expect_val("t3b_pix_hi", int'(cap_q[11]), 9'h100);
            expect_val("t3b_pix_lo", int'(cap_q[18]), 9'h100);
        end else expect_val("t3b_nbytes", cap_q.size(), 19);

        // out-of-range row
        directed_req(4, 12, 2);
        wait_idle(10);
        expect_val("t4_nbytes", cap_q.size(), 0);
        expect_val("t4_done_latency", done_cyc - req_cyc, 1);

        // reset in the middle of the pixel stream
        directed_req(3, 5, 3);
        repeat (30) step();
        rst = 1'b1;
        #1;
        check_reset_vals("t6_async_reset");
        exp_q.delete();
        @(negedge clk);
        check_reset_vals("t6_held_reset");
        rst = 1'b0;
        do_init();

        // randomized requests, many landing while busy
        for (int i = 0; i < 2500; i++) begin
            step();
            drive($urandom_range(0, 5) == 0, $urandom_range(0, 15), $urandom_range(0, 15),
                  $urandom_range(0, 7));
        end
        wait_idle(100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
